// File: rtl/fme_residual_collector.sv
// Ping-pong residual buffer between fractional ME and the transform stage.
// Captures 8-row residual blocks plus winner metadata; replays them row by row over valid/ready.
module fme_residual_collector #(
  parameter int DATAWIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        res_valid,
  input  logic signed [DATAWIDTH:0]   res_0,
  input  logic signed [DATAWIDTH:0]   res_1,
  input  logic signed [DATAWIDTH:0]   res_2,
  input  logic signed [DATAWIDTH:0]   res_3,
  input  logic signed [DATAWIDTH:0]   res_4,
  input  logic signed [DATAWIDTH:0]   res_5,
  input  logic signed [DATAWIDTH:0]   res_6,
  input  logic signed [DATAWIDTH:0]   res_7,
  input  logic [5:0]                  address_best_sad,
  input  logic [DATAWIDTH+8:0]        best_sad,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATAWIDTH:0]   out_0,
  output logic signed [DATAWIDTH:0]   out_1,
  output logic signed [DATAWIDTH:0]   out_2,
  output logic signed [DATAWIDTH:0]   out_3,
  output logic signed [DATAWIDTH:0]   out_4,
  output logic signed [DATAWIDTH:0]   out_5,
  output logic signed [DATAWIDTH:0]   out_6,
  output logic signed [DATAWIDTH:0]   out_7,
  output logic [2:0]                  out_row,
  output logic                        out_last,
  output logic [5:0]                  out_address,
  output logic [DATAWIDTH+8:0]        out_sad,
  output logic                        overflow
);

  localparam int SW   = DATAWIDTH + 1;
  localparam int SADW = DATAWIDTH + 9;

  typedef logic signed [SW-1:0] samp_t;

  samp_t           row_in [8];
  samp_t           mem_q [2][8][8];
  logic [5:0]      addr_mem_q [2];
  logic [SADW-1:0] sad_mem_q [2];

  logic       wr_bank_q, wr_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_row_q, rd_row_d;
  logic [1:0] full_q, full_d;
  logic       drop_q, drop_d;
  logic       overflow_q, overflow_d;
  logic       drop_now, wr_en, rd_fire;

  assign row_in[0] = res_0;
  assign row_in[1] = res_1;
  assign row_in[2] = res_2;
  assign row_in[3] = res_3;
  assign row_in[4] = res_4;
  assign row_in[5] = res_5;
  assign row_in[6] = res_6;
  assign row_in[7] = res_7;

  // Drop decision is taken live on row 0 and then held for rows 1..7 of the same block.
  assign drop_now = (wr_row_q == 3'd0) ? full_q[wr_bank_q] : drop_q;
  assign wr_en    = res_valid && !drop_now;
  assign rd_fire  = out_valid && out_ready;

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_row_d   = wr_row_q;
    rd_bank_d  = rd_bank_q;
    rd_row_d   = rd_row_q;
    full_d     = full_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;

    if (rd_fire) begin
      rd_row_d = rd_row_q + 3'd1;
      if (rd_row_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end

    // Row counter advances even through dropped blocks to keep row alignment.
    if (res_valid) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd0) begin
        drop_d = full_q[wr_bank_q];
        if (full_q[wr_bank_q]) overflow_d = 1'b1;
      end
      if (wr_row_q == 3'd7) begin
        if (drop_now) begin
          drop_d = 1'b0;
        end else begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_row_q   <= 3'd0;
      rd_bank_q  <= 1'b0;
      rd_row_q   <= 3'd0;
      full_q     <= 2'b00;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      rd_bank_q  <= rd_bank_d;
      rd_row_q   <= rd_row_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked solely by full_q.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int j = 0; j < 8; j++) begin
        mem_q[wr_bank_q][wr_row_q][j] <= row_in[j];
      end
      if (wr_row_q == 3'd7) begin
        addr_mem_q[wr_bank_q] <= address_best_sad;
        sad_mem_q[wr_bank_q]  <= best_sad;
      end
    end
  end

  assign out_valid   = full_q[rd_bank_q];
  assign out_row     = out_valid ? rd_row_q : 3'd0;
  assign out_last    = out_valid && (rd_row_q == 3'd7);
  assign out_address = out_valid ? addr_mem_q[rd_bank_q] : 6'd0;
  assign out_sad     = out_valid ? sad_mem_q[rd_bank_q] : '0;
  assign out_0       = out_valid ? mem_q[rd_bank_q][rd_row_q][0] : '0;
  assign out_1       = out_valid ? mem_q[rd_bank_q][rd_row_q][1] : '0;
  assign out_2       = out_valid ? mem_q[rd_bank_q][rd_row_q][2] : '0;
  assign out_3       = out_valid ? mem_q[rd_bank_q][rd_row_q][3] : '0;
  assign out_4       = out_valid ? mem_q[rd_bank_q][rd_row_q][4] : '0;
  assign out_5       = out_valid ? mem_q[rd_bank_q][rd_row_q][5] : '0;
  assign out_6       = out_valid ? mem_q[rd_bank_q][rd_row_q][6] : '0;
  assign out_7       = out_valid ? mem_q[rd_bank_q][rd_row_q][7] : '0;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fme_residual_collector.sv
// Directed bench for fme_residual_collector: streams blocks, records accepted beats, compares to hand-built rows.
module tb_fme_residual_collector;

  typedef struct packed {
    logic [71:0] data;
    logic [2:0]  row;
    logic        last;
    logic [5:0]  addr;
    logic [16:0] sad;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              res_valid;
  logic signed [8:0] res_in [8];
  logic [5:0]        addr_in;
  logic [16:0]       sad_in;
  logic              out_valid, out_ready, out_last, overflow;
  logic signed [8:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [2:0]        out_row;
  logic [5:0]        out_address;
  logic [16:0]       out_sad;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  beat_t cap_q[$];
  int    cap_cyc[$];
  bit    gap_done;

  fme_residual_collector #(.DATAWIDTH(8)) dut (
    .clock(clk), .reset(rst), .res_valid(res_valid),
    .res_0(res_in[0]), .res_1(res_in[1]), .res_2(res_in[2]), .res_3(res_in[3]),
    .res_4(res_in[4]), .res_5(res_in[5]), .res_6(res_in[6]), .res_7(res_in[7]),
    .address_best_sad(addr_in), .best_sad(sad_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_0(o0), .out_1(o1), .out_2(o2), .out_3(o3),
    .out_4(o4), .out_5(o5), .out_6(o6), .out_7(o7),
    .out_row(out_row), .out_last(out_last), .out_address(out_address),
    .out_sad(out_sad), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cap_q.push_back({{o7, o6, o5, o4, o3, o2, o1, o0}, out_row, out_last, out_address, out_sad});
      cap_cyc.push_back(cyc);
    end
  end

  function automatic logic [71:0] mk_row(input int base, input bit neg, input int k);
    logic [71:0] d;
    logic [8:0]  v;
    for (int j = 0; j < 8; j++) begin
      v = 9'(base + k * 8 + j);
      if (neg && j == 0) v = 9'h1FF;
      if (neg && j == 7) v = 9'h100;
      d[j*9 +: 9] = v;
    end
    return d;
  endfunction

  function automatic beat_t exp_beat(input int base, input bit neg, input int k,
                                     input logic [5:0] a, input logic [16:0] s);
    beat_t b;
    b.data = mk_row(base, neg, k);
    b.row  = 3'(k);
    b.last = (k == 7);
    b.addr = a;
    b.sad  = s;
    return b;
  endfunction

  task automatic drive_row(input logic [71:0] d, input logic [5:0] a, input logic [16:0] s);
    res_valid = 1'b1;
    for (int j = 0; j < 8; j++) res_in[j] = d[j*9 +: 9];
    addr_in = a;
    sad_in  = s;
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic send_block(input int base, input bit neg, input logic [5:0] a,
                            input logic [16:0] s, input int maxgap);
    for (int k = 0; k < 8; k++) begin
      drive_row(mk_row(base, neg, k), a, s);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cap_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_row !== 3'd0) begin n_fail++; $display("FAIL reset_row got=%0d exp=0", out_row); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", out_last); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if ({o7, o6, o5, o4, o3, o2, o1, o0, out_sad, out_address} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {o7, o6, o5, o4, o3, o2, o1, o0, out_sad, out_address});
    end
  endtask

  task automatic test_single_block();
    beat_t got, exp;
    cap_q.delete(); cap_cyc.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_row(mk_row(0, 0, k), 6'd17, 17'd300);
      if (k == 6) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
      end
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got=%b exp=1", out_valid); end
    repeat (8) begin @(posedge clk); #1; end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    n_checks++; if (cap_q.size() != 8) begin n_fail++; $display("FAIL single_count got=%0d exp=8", cap_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = exp_beat(0, 0, i, 6'd17, 17'd300);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL single_beat%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_negative();
    beat_t got, exp;
    bit ok;
    cap_q.delete(); cap_cyc.delete();
    out_ready = 1'b1;
    send_block(100, 1, 6'd63, 17'h1FFFF, 0);
    wait_beats(8, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL neg_timeout got=%0d exp=8", cap_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = exp_beat(100, 1, i, 6'd63, 17'h1FFFF);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL neg_beat%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_back_pressure();
    beat_t got, exp;
    bit ok;
    cap_q.delete(); cap_cyc.delete();
    out_ready = 1'b0;
    send_block(200, 0, 6'd1, 17'd1000, 0);
    n_checks++; if (out_valid !== 1'b1 || out_row !== 3'd0) begin
      n_fail++; $display("FAIL bp_present got=%b/%0d exp=1/0", out_valid, out_row);
    end
    send_block(300, 0, 6'd2, 17'd2000, 0);
    repeat (12) begin @(posedge clk); #1; end
    n_checks++; if ({o7, o6, o5, o4, o3, o2, o1, o0} !== mk_row(200, 0, 0) || out_row !== 3'd0) begin
      n_fail++; $display("FAIL bp_hold got=%h/%0d exp=%h/0", {o7, o6, o5, o4, o3, o2, o1, o0}, out_row, mk_row(200, 0, 0));
    end
    n_checks++; if (cap_q.size() != 0) begin n_fail++; $display("FAIL bp_no_beats got=%0d exp=0", cap_q.size()); end
    out_ready = 1'b1;
    wait_beats(16, 60, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%0d exp=16", cap_q.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = (i < 8) ? exp_beat(200, 0, i, 6'd1, 17'd1000) : exp_beat(300, 0, i - 8, 6'd2, 17'd2000);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got, exp); end
    end
    if (ok) begin
      n_checks++; if (cap_cyc[15] - cap_cyc[0] != 15) begin
        n_fail++; $display("FAIL bp_back_to_back got=%0d exp=15", cap_cyc[15] - cap_cyc[0]);
      end
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    beat_t got, exp;
    bit ok;
    cap_q.delete(); cap_cyc.delete();
    out_ready = 1'b0;
    send_block(400, 0, 6'd4, 17'd40, 0);
    send_block(500, 0, 6'd5, 17'd50, 0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    for (int k = 0; k < 8; k++) begin
      drive_row(mk_row(600, 0, k), 6'd6, 17'd60);
      if (k == 0) begin
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_row0 got=%b exp=1", overflow); end
      end
    end
    out_ready = 1'b1;
    wait_beats(16, 60, ok);
    repeat (20) begin @(posedge clk); #1; end
    n_checks++; if (cap_q.size() != 16) begin n_fail++; $display("FAIL ovf_count got=%0d exp=16", cap_q.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = (i < 8) ? exp_beat(400, 0, i, 6'd4, 17'd40) : exp_beat(500, 0, i - 8, 6'd5, 17'd50);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, got, exp); end
    end
    cap_q.delete(); cap_cyc.delete();
    send_block(700, 0, 6'd7, 17'd70, 0);
    wait_beats(8, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_d_timeout got=%0d exp=8", cap_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = exp_beat(700, 0, i, 6'd7, 17'd70);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ovf_d_beat%0d got=%h exp=%h", i, got, exp); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid_block();
    beat_t got, exp;
    bit ok;
    out_ready = 1'b0;
    send_block(800, 0, 6'd8, 17'd80, 0);
    for (int k = 0; k < 5; k++) drive_row(mk_row(900, 0, k), 6'd9, 17'd90);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
    cap_q.delete(); cap_cyc.delete();
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (cap_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle got=%0d/%b exp=0/0", cap_q.size(), out_valid);
    end
    send_block(50, 0, 6'd33, 17'd77, 0);
    wait_beats(8, 40, ok);
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if (cap_q.size() != 8) begin n_fail++; $display("FAIL rst_mid_count got=%0d exp=8", cap_q.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = exp_beat(50, 0, i, 6'd33, 17'd77);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rst_mid_beat%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_gapped();
    beat_t got, exp;
    bit ok;
    cap_q.delete(); cap_cyc.delete();
    gap_done = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send_block(1000, 0, 6'd10, 17'd111, 3);
        send_block(1100, 0, 6'd11, 17'd222, 3);
        gap_done = 1'b1;
      end
      begin
        for (int c = 0; c < 200 && !gap_done; c++) begin
          out_ready = ~out_ready;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_beats(16, 60, ok);
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (cap_q.size() != 16) begin n_fail++; $display("FAIL gap_count got=%0d exp=16", cap_q.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '0;
      exp = (i < 8) ? exp_beat(1000, 0, i, 6'd10, 17'd111) : exp_beat(1100, 0, i - 8, 6'd11, 17'd222);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL gap_beat%0d got=%h exp=%h", i, got, exp); end
    end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL gap_overflow got=%b exp=0", overflow); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    res_valid = 1'b0;
    for (int j = 0; j < 8; j++) res_in[j] = '0;
    addr_in = '0;
    sad_in = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_block();
    test_negative();
    test_back_pressure();
    test_overflow();
    test_reset_mid_block();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fme_residual_collector.md
Name: fme_residual_collector

Overview:
- Downstream stage of the fractional motion estimation top level.
- Captures the 8 residual rows it emits per 8x8 block, each row being 8 signed samples of DATAWIDTH+1 bits, plus the winning candidate address and SAD.
- Stores them in a two-bank ping-pong buffer and replays each block row-by-row to the transform stage over a valid/ready handshake.
- Lets the FME keep running while the previous block drains.

Parameters:
DATAWIDTH, 8, pixel width; residual samples are DATAWIDTH+1 bits, SAD is DATAWIDTH+9 bits.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
res_valid  input  1  one residual row present this cycle; 8 consecutive strobes form one block
res_0..res_7  input  DATAWIDTH+1 each  residual samples of the current row
address_best_sad  input  6  winning fractional candidate index, sampled with row 7
best_sad  input  DATAWIDTH+9  winning SAD, sampled with row 7
out_valid  output  1  a buffered row is presented
out_ready  input  1  downstream accepts the presented row
out_0..out_7  output  DATAWIDTH+1 each  presented row samples
out_row  output  3  index 0..7 of presented row
out_last  output  1  presented row is row 7 of its block
out_address  output  6  address_best_sad of presented block
out_sad  output  DATAWIDTH+9  best_sad of presented block
overflow  output  1  sticky: at least one block dropped

Behaviour:
- Reset (synchronous, active-high, sampled on clock edge): the following are all cleared.
  - wr_bank=0, wr_row=0, rd_bank=0, rd_row=0.
  - full[1:0]=0, drop=0, overflow=0.
  - Outputs: out_valid=0, out_row=0, out_last=0; out_0..7/out_address/out_sad=0 (buffer contents are don't-care, but outputs are masked to 0 when out_valid=0).
- Reset mid-operation discards any partial or complete block in both banks; no row is emitted after reset until 8 new rows arrive.
- Write side, on res_valid:
  - If wr_row==0: drop <= full[wr_bank]; if full[wr_bank], overflow <= 1.
  - The drop decision applies to the whole block, rows 0..7.
  - When not dropping (current-cycle decision for row 0, drop register for rows 1..7): bank[wr_bank].row[wr_row] <= res_0..res_7.
  - wr_row <= wr_row+1 (wraps 7->0), always, including in dropped blocks, so row alignment is preserved.
  - At wr_row==7 and not dropping:
    - bank metadata <= {address_best_sad, best_sad};
    - full[wr_bank] <= 1;
    - wr_bank toggles.
  - At wr_row==7 and dropping: wr_bank is unchanged and drop clears.
- Read side:
  - out_valid = full[rd_bank].
  - out_0..7 = bank[rd_bank].row[rd_row]; out_row = rd_row; out_last = (rd_row==7); out_address and out_sad come from bank[rd_bank] metadata.
  - On out_valid && out_ready: rd_row <= rd_row+1.
  - On the beat where rd_row==7: full[rd_bank] <= 0, rd_bank toggles, rd_row <= 0.
  - Presented data stays stable while out_valid && !out_ready.
- Latency:
  - Row 7 written on edge N -> out_valid=1 after edge N (visible in cycle N+1).
  - Minimum full-block drain is 8 cycles with out_ready held high.
- Simultaneous events:
  - Completing a write and finishing a read in the same cycle always touch different banks; both full-bit updates take effect.
  - Freeing bank B and starting row 0 into bank B in the same cycle uses the pre-edge full[B]=1, so the block is dropped (conservative, no bypass).
- res_valid gaps between rows of a block are legal; counters simply hold.
- overflow clears only on reset.

Test Plan:
- Single block with out_ready=1: rows k=0..7 with res_j = k*8+j, best_sad=300, address=17.
  -> out_valid rises the cycle after row 7; 8 beats with out_row 0..7 and matching samples; out_last only on beat 7; out_sad=300, out_address=17 on every beat; out_valid then 0.
- Negative residuals: res_0 = 9'h1FF (-1), res_7 = 9'h100 (-256).
  -> passed bit-exact.
- Back-pressure: out_ready=0 for 20 cycles after block A completes, with block B streamed meanwhile.
  -> A row 0 held stable; B fills bank 1; releasing out_ready gives A's 8 beats then B's 8 beats back-to-back; overflow=0.
- Overflow: out_ready=0 while blocks A, B, C are streamed.
  -> C dropped; overflow=1 from C's row-0 edge; output sequence is A then B only; a block D sent after draining appears correctly, rows aligned.
- Reset mid-block: reset pulsed after row 4 of block A, with block B pending in the other bank.
  -> out_valid=0 next cycle, overflow=0; a fresh 8-row block emerges intact with out_row starting at 0.
- Gapped input: rows separated by random 0-3 idle cycles, with out_ready toggling every cycle.
  -> data order and values identical to the gap-free case, and no beat is duplicated or lost.
